// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO and its read/write streamers.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;
  typedef logic [15:0]               beat_cnt_t;

  // Packet beat counter advance: wraps to 0 after the final beat.
  function automatic beat_cnt_t beat_next(input beat_cnt_t cur, input beat_cnt_t last);
    return (cur == last) ? '0 : cur + 16'd1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ordered buffer. Slot 0 is always the head; slot 1 only ever
// holds the word behind it, so a pop shifts slot 1 forward.
module stream_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       occ_q, occ_d;

  // Next-state for slots and occupancy; simultaneous push+pop keeps occupancy.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = slot0_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ_q == 2'd0));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side master for the synchronous FIFO: issues rd_en, captures the
// registered read data one cycle later into a 2-entry buffer, and presents
// it as a framed valid/ready stream.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int PKT_LEN    = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err_underflow,
  output logic [CNT_W-1:0]      words_sent
);

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(PKT_LEN - 1);

  logic             inflight_q;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       committed;
  beat_cnt_t        beat_q, beat_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             err_q, err_d;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Words buffered or in flight after this cycle's pop; a read is only
  // issued if its data is guaranteed a slot when it lands.
  assign committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = enable && !fifo_empty && (committed < 3'd2);

  // In-flight flag: the FIFO presents read data exactly one cycle after rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= fifo_rd_en;
  end

  stream_skid_buf #(.WIDTH(FIFO_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  // Framing, handshake count and sticky underflow next-state.
  always_comb begin
    beat_d  = beat_q;
    words_d = words_q;
    err_d   = err_q | fifo_underflow;
    if (pop) begin
      beat_d  = beat_next(beat_q, LAST_BEAT);
      words_d = words_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Framing, counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign m_last        = m_valid && (beat_q == LAST_BEAT);
  assign words_sent    = words_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a queue-based FIFO model feeds the DUT, an
// expected-stream scoreboard checks every cycle, and directed tests pin
// latency, backpressure, framing, error and reset behaviour with literals.
module tb_fifo_rd_streamer;

  localparam int W  = 16;
  localparam int PL = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          err_underflow;
  logic [CW-1:0] words_sent;

  fifo_rd_streamer #(.FIFO_WIDTH(W), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .err_underflow  (err_underflow),
    .words_sent     (words_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] load_q[$];
  logic [W-1:0] exp_q[$];
  int           rd_log[$];
  int           pop_cyc[$];
  logic [W-1:0] pop_dat[$];
  logic         pop_last[$];
  int           cyc = 0;
  int           mpops = 0;
  int           outstanding = 0;
  logic         merr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // FIFO with 1-cycle registered read data; shares the reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      load_q.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
      while (load_q.size() > 0) fq.push_back(load_q.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: outputs must follow the ordered word stream and the framing rules.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (!rst_n) begin
      chk("rst_rd_en",  64'(fifo_rd_en), 64'(0));
      chk("rst_valid",  64'(m_valid), 64'(0));
      chk("rst_data",   64'(m_data), 64'(0));
      chk("rst_last",   64'(m_last), 64'(0));
      chk("rst_err",    64'(err_underflow), 64'(0));
      chk("rst_words",  64'(words_sent), 64'(0));
      exp_q.delete();
      mpops = 0;
      outstanding = 0;
      merr = 1'b0;
    end else begin
      chk("err_underflow", 64'(err_underflow), 64'(merr));
      if (fifo_underflow) merr = 1'b1;
      chk("rd_when_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
      chk("words_sent", 64'(words_sent), 64'(mpops));
      if (m_valid) begin
        chk("valid_has_word", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) chk("m_data", 64'(m_data), 64'(exp_q[0]));
        chk("m_last", 64'(m_last), 64'((mpops % PL) == PL - 1));
      end else begin
        chk("m_last_idle", 64'(m_last), 64'(0));
      end
      if (fifo_rd_en) begin
        outstanding++;
        rd_log.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mpops++;
        outstanding--;
        pop_cyc.push_back(cyc);
        pop_dat.push_back(m_data);
        pop_last.push_back(m_last);
      end
      chk("outstanding_le2", 64'(outstanding <= 2), 64'(1));
    end
  end

  task automatic load(input logic [W-1:0] w);
    load_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    pop_cyc.delete();
    pop_dat.delete();
    pop_last.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_pops(input string name, input logic [W-1:0] base, input int n);
    chk({name, "_cnt"}, 64'(pop_dat.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < pop_dat.size()) chk({name, "_data"}, 64'(pop_dat[i]), 64'(W'(base + W'(i))));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("init_valid", 64'(m_valid), 64'(0));
    chk("init_words", 64'(words_sent), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 5 words back to back
    @(negedge clk);
    clear_logs();
    for (int i = 0; i < 5; i++) load(W'(16'hA001 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("stream_rd_cnt", 64'(rd_log.size()), 64'(5));
    if (rd_log.size() == 5) chk("stream_rd_contig", 64'(rd_log[4] - rd_log[0]), 64'(4));
    if (rd_log.size() > 0 && pop_cyc.size() > 0)
      chk("stream_latency", 64'(pop_cyc[0] - rd_log[0]), 64'(2));
    if (pop_cyc.size() == 5) chk("stream_vld_contig", 64'(pop_cyc[4] - pop_cyc[0]), 64'(4));
    chk_pops("stream", 16'hA001, 5);
    chk("stream_words", 64'(words_sent), 64'(5));

    // Backpressure: only 2 reads while stalled, head held
    do_reset();
    clear_logs();
    for (int i = 0; i < 6; i++) load(W'(16'hB001 + i));
    enable = 1'b1;
    m_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("bp_rd_cnt", 64'(rd_log.size()), 64'(2));
    chk("bp_valid", 64'(m_valid), 64'(1));
    chk("bp_head", 64'(m_data), 64'(16'hB001));
    m_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("bp_rd_total", 64'(rd_log.size()), 64'(6));
    chk_pops("bp", 16'hB001, 6);
    chk("bp_words", 64'(words_sent), 64'(6));

    // Framing: PKT_LEN=4, ready toggling
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) load(W'(16'hC001 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      m_ready = ~m_ready;
    end
    #1;
    chk_pops("frame", 16'hC001, 8);
    for (int i = 0; i < 8; i++)
      if (i < pop_last.size()) chk("frame_last", 64'(pop_last[i]), 64'(i == 3 || i == 7));
    chk("frame_words", 64'(words_sent), 64'(8));
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) load(W'(16'hC009 + i));
    repeat (10) @(negedge clk);
    #1;
    chk("frame2_cnt", 64'(pop_last.size()), 64'(12));
    if (pop_last.size() == 12) begin
      chk("frame2_first", 64'(pop_last[8]), 64'(0));
      chk("frame2_last", 64'(pop_last[11]), 64'(1));
    end

    // Empty FIFO and sticky underflow error
    do_reset();
    clear_logs();
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("empty_rd_cnt", 64'(rd_log.size()), 64'(0));
    chk("empty_valid", 64'(m_valid), 64'(0));
    @(negedge clk);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    #1;
    chk("err_set", 64'(err_underflow), 64'(1));
    repeat (5) @(negedge clk);
    #1;
    chk("err_sticky", 64'(err_underflow), 64'(1));
    do_reset();
    #1;
    chk("err_cleared", 64'(err_underflow), 64'(0));

    // Enable drop right after one read
    clear_logs();
    for (int i = 0; i < 3; i++) load(W'(16'hD001 + i));
    m_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("en_rd_cnt", 64'(rd_log.size()), 64'(1));
    chk_pops("en_drop", 16'hD001, 1);
    chk("en_words", 64'(words_sent), 64'(1));
    enable = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("en_rd_total", 64'(rd_log.size()), 64'(3));
    chk_pops("en_resume", 16'hD001, 3);

    // Asynchronous reset mid-run with data buffered and in flight
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) load(W'(16'hE001 + i));
    enable = 1'b1;
    m_ready = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("mid_rst_data", 64'(m_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_pops", 64'(pop_dat.size()), 64'(0));
    chk("post_rst_valid", 64'(m_valid), 64'(0));
    load(16'hF001);
    repeat (6) @(negedge clk);
    #1;
    chk_pops("post_rst", 16'hF001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
